// File: rtl/ucsbece154b_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_mem_pkg
// Description : Shared types and constants for the SDRAM read-port arbiter.
// Revision    : 1.0
// ============================================================================
package ucsbece154b_mem_pkg;

    localparam int DEFAULT_BLOCK_WORDS = 4;
    localparam int DEFAULT_TIMEOUT     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IC   = 2'b01,
        OWN_PF   = 2'b10
    } owner_t;

    // Lowest address bit of the block tag: byte offset plus word-in-block offset.
    function automatic int tag_lsb(input int words);
        return 2 + $clog2(words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_burst_counter.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_burst_counter
// Description : Burst beat counter and request wait/timeout counter.
// Revision    : 1.0
// ============================================================================
module ucsbece154b_burst_counter #(
    parameter int BLOCK_WORDS = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          beat_clr,
    input  logic                          beat_en,
    input  logic                          wait_clr,
    input  logic                          wait_en,
    output logic [$clog2(BLOCK_WORDS):0]  beat_cnt,
    output logic                          beat_last,
    output logic                          wait_expired
);

    localparam int BEAT_W = $clog2(BLOCK_WORDS) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [WAIT_W-1:0] C_LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    logic [BEAT_W-1:0] r_beat;
    logic [WAIT_W-1:0] r_wait;

    always_ff @(posedge clk) begin
        if (reset || beat_clr) begin
            r_beat <= '0;
        end else if (beat_en) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || wait_clr) begin
            r_wait <= '0;
        end else if (wait_en) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign beat_cnt     = r_beat;
    assign beat_last    = (r_beat == C_LAST_BEAT);
    assign wait_expired = (r_wait == C_LAST_WAIT);

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_mem_arbiter
// Description : Demand-first arbiter sharing the SDRAM read port between the
//               icache and the next-line prefetcher, with in-flight merging.
// Revision    : 1.0
// ============================================================================
module ucsbece154b_mem_arbiter
    import ucsbece154b_mem_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ic_req,
    input  logic [31:0]                     ic_addr,
    output logic                            ic_dataReady,
    output logic [31:0]                     ic_data,
    output logic [$clog2(BLOCK_WORDS)-1:0]  ic_blockIndex,
    input  logic                            pf_req,
    input  logic [31:0]                     pf_addr,
    output logic                            pf_dataReady,
    output logic [31:0]                     pf_data,
    output logic [$clog2(BLOCK_WORDS)-1:0]  pf_blockIndex,
    output logic                            memReadRequest,
    output logic [31:0]                     memReadAddress,
    input  logic [31:0]                     memDataIn,
    input  logic                            memDataReady,
    input  logic [$clog2(BLOCK_WORDS)-1:0]  memBlockIndex,
    output logic [1:0]                      owner,
    output logic                            merged,
    output logic                            timeout_err
);

    localparam int TAG_LSB = tag_lsb(BLOCK_WORDS);
    localparam int BEAT_W  = $clog2(BLOCK_WORDS) + 1;

    arb_state_t        r_state, w_state_n;
    owner_t            r_owner, w_owner_n;
    logic              r_merged, w_merged_n;
    logic [31:0]       r_addr, w_addr_n;
    logic              w_timeout;

    logic [BEAT_W-1:0] w_beat_cnt;
    logic              w_beat_last;
    logic              w_wait_expired;
    logic              w_active;
    logic              w_tag_hit;
    logic              w_merge_window;

    assign w_active = (r_state == REQ) || (r_state == BURST);

    ucsbece154b_burst_counter #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .TIMEOUT     (TIMEOUT)
    ) u_burst_counter (
        .clk          (clk),
        .reset        (reset),
        .beat_clr     (!w_active),
        .beat_en      (w_active && memDataReady),
        .wait_clr     (r_state != REQ),
        .wait_en      (r_state == REQ),
        .beat_cnt     (w_beat_cnt),
        .beat_last    (w_beat_last),
        .wait_expired (w_wait_expired)
    );

    // Merging is only useful while beat 0 has not yet been delivered; a merge
    // taken on the beat-0 cycle itself would leave the icache short a word.
    assign w_tag_hit      = (ic_addr[31:TAG_LSB] == r_addr[31:TAG_LSB]);
    assign w_merge_window = (r_owner == OWN_PF) && w_active &&
                            (w_beat_cnt == '0) && !memDataReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= OWN_NONE;
            r_merged <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_owner  <= w_owner_n;
            r_merged <= w_merged_n;
            r_addr   <= w_addr_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_owner_n  = r_owner;
        w_merged_n = r_merged;
        w_addr_n   = r_addr;
        w_timeout  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (ic_req) begin
                    w_addr_n  = ic_addr;
                    w_owner_n = OWN_IC;
                    w_state_n = REQ;
                end else if (pf_req) begin
                    w_addr_n  = pf_addr;
                    w_owner_n = OWN_PF;
                    w_state_n = REQ;
                end
            end
            REQ: begin
                if (memDataReady) begin
                    w_state_n = w_beat_last ? GAP : BURST;
                end else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                    w_state_n = GAP;
                end
            end
            BURST: begin
                if (memDataReady && w_beat_last) begin
                    w_state_n = GAP;
                end
            end
            GAP: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (ic_req && w_tag_hit && w_merge_window) begin
            w_merged_n = 1'b1;
        end

        // Ownership ends as soon as the transaction leaves REQ/BURST.
        if ((w_state_n == GAP) || (w_state_n == IDLE)) begin
            w_owner_n  = OWN_NONE;
            w_merged_n = 1'b0;
        end
    end

    assign memReadRequest = (r_state == REQ) && !memDataReady;
    assign memReadAddress = r_addr;

    assign ic_data       = memDataIn;
    assign pf_data       = memDataIn;
    assign ic_blockIndex = memBlockIndex;
    assign pf_blockIndex = memBlockIndex;

    assign ic_dataReady = memDataReady && w_active &&
                          ((r_owner == OWN_IC) || r_merged);
    assign pf_dataReady = memDataReady && w_active && (r_owner == OWN_PF);

    assign owner       = r_owner;
    assign merged      = r_merged;
    assign timeout_err = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucsbece154b_mem_arbiter
// Description : Directed vector bench for the SDRAM read-port arbiter.
// Revision    : 1.0
// ============================================================================
module tb_ucsbece154b_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req, pf_req, memDataReady;
    logic [31:0] ic_addr, pf_addr, memDataIn;
    logic [1:0]  memBlockIndex;
    logic        ic_dataReady, pf_dataReady, memReadRequest, merged, timeout_err;
    logic [31:0] ic_data, pf_data, memReadAddress;
    logic [1:0]  ic_blockIndex, pf_blockIndex, owner;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ucsbece154b_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_dataReady   (ic_dataReady),
        .ic_data        (ic_data),
        .ic_blockIndex  (ic_blockIndex),
        .pf_req         (pf_req),
        .pf_addr        (pf_addr),
        .pf_dataReady   (pf_dataReady),
        .pf_data        (pf_data),
        .pf_blockIndex  (pf_blockIndex),
        .memReadRequest (memReadRequest),
        .memReadAddress (memReadAddress),
        .memDataIn      (memDataIn),
        .memDataReady   (memDataReady),
        .memBlockIndex  (memBlockIndex),
        .owner          (owner),
        .merged         (merged),
        .timeout_err    (timeout_err)
    );

    typedef struct {
        logic        rst;
        logic        icr;
        logic [31:0] ica;
        logic        pfr;
        logic [31:0] pfa;
        logic        mr;
        logic [31:0] md;
        logic [1:0]  mi;
        logic        e_req;
        logic        e_icr;
        logic        e_pfr;
        logic [1:0]  e_own;
        logic        e_mrg;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic icr, input logic [31:0] ica,
                       input logic pfr, input logic [31:0] pfa,
                       input logic mr, input logic [31:0] md, input logic [1:0] mi,
                       input logic e_req, input logic e_icr, input logic e_pfr,
                       input logic [1:0] e_own, input logic e_mrg, input logic [31:0] e_addr);
        vec_t v;
        v.rst = rst; v.icr = icr; v.ica = ica; v.pfr = pfr; v.pfa = pfa;
        v.mr = mr; v.md = md; v.mi = mi;
        v.e_req = e_req; v.e_icr = e_icr; v.e_pfr = e_pfr;
        v.e_own = e_own; v.e_mrg = e_mrg; v.e_addr = e_addr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic mr, input logic [31:0] md, input logic [1:0] mi);
        memDataReady  = mr;
        memDataIn     = md;
        memBlockIndex = mi;
    endtask

    initial begin
        int req_n, tmo_n, tmo_at, rdy_n;
        logic [1:0] gap_owner;

        reset = 1'b1; ic_req = 0; pf_req = 0; ic_addr = 0; pf_addr = 0;
        drive_mem(0, 32'h0, 2'd0);

        // Plain icache miss, SDRAM answers after three request cycles.
        add(0,1,'h140,0,0,     0,0,0,        0,0,0,0,0,'h000);
        add(0,1,'h140,0,0,     0,0,0,        1,0,0,1,0,'h140);
        add(0,1,'h140,0,0,     0,0,0,        1,0,0,1,0,'h140);
        add(0,1,'h140,0,0,     0,0,0,        1,0,0,1,0,'h140);
        add(0,1,'h140,0,0,     1,'hA0,0,     0,1,0,1,0,'h140);
        add(0,1,'h140,0,0,     1,'hA1,1,     0,1,0,1,0,'h140);
        add(0,1,'h140,0,0,     1,'hA2,2,     0,1,0,1,0,'h140);
        add(0,1,'h140,0,0,     1,'hA3,3,     0,1,0,1,0,'h140);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h140);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h140);
        // Simultaneous requests to different blocks: demand first.
        add(0,1,'h200,1,'h300, 0,0,0,        0,0,0,0,0,'h140);
        add(0,1,'h200,1,'h300, 0,0,0,        1,0,0,1,0,'h200);
        add(0,1,'h200,1,'h300, 1,'hB0,0,     0,1,0,1,0,'h200);
        add(0,1,'h200,1,'h300, 1,'hB1,1,     0,1,0,1,0,'h200);
        add(0,1,'h200,1,'h300, 1,'hB2,2,     0,1,0,1,0,'h200);
        add(0,1,'h200,1,'h300, 1,'hB3,3,     0,1,0,1,0,'h200);
        add(0,0,0,1,'h300,     0,0,0,        0,0,0,0,0,'h200);
        add(0,0,0,1,'h300,     0,0,0,        0,0,0,0,0,'h200);
        add(0,0,0,1,'h300,     0,0,0,        1,0,0,2,0,'h300);
        add(0,0,0,1,'h300,     1,'hD0,0,     0,0,1,2,0,'h300);
        add(0,0,0,1,'h300,     1,'hD1,1,     0,0,1,2,0,'h300);
        add(0,0,0,1,'h300,     1,'hD2,2,     0,0,1,2,0,'h300);
        add(0,0,0,1,'h300,     1,'hD3,3,     0,0,1,2,0,'h300);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h300);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h300);
        // Demand to the block being prefetched, arriving while still in REQ.
        add(0,0,0,1,'h400,     0,0,0,        0,0,0,0,0,'h300);
        add(0,1,'h408,1,'h400, 0,0,0,        1,0,0,2,0,'h400);
        add(0,1,'h408,1,'h400, 0,0,0,        1,0,0,2,1,'h400);
        add(0,1,'h408,1,'h400, 1,'hE0,0,     0,1,1,2,1,'h400);
        add(0,1,'h408,1,'h400, 1,'hE1,1,     0,1,1,2,1,'h400);
        add(0,1,'h408,1,'h400, 1,'hE2,2,     0,1,1,2,1,'h400);
        add(0,1,'h408,1,'h400, 1,'hE3,3,     0,1,1,2,1,'h400);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h400);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h400);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h400);
        // Reset during beat 1 with SDRAM still streaming afterwards.
        add(0,1,'h500,0,0,     0,0,0,        0,0,0,0,0,'h400);
        add(0,1,'h500,0,0,     1,'hF0,0,     0,1,0,1,0,'h500);
        add(1,1,'h500,0,0,     1,'hF1,1,     0,1,0,1,0,'h500);
        add(0,0,0,0,0,         1,'hF2,2,     0,0,0,0,0,'h000);
        add(0,0,0,0,0,         0,0,0,        0,0,0,0,0,'h000);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            ic_req  = vecs[i].icr; ic_addr = vecs[i].ica;
            pf_req  = vecs[i].pfr; pf_addr = vecs[i].pfa;
            drive_mem(vecs[i].mr, vecs[i].md, vecs[i].mi);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                64'({memReadRequest, ic_dataReady, pf_dataReady, owner, merged,
                     timeout_err, memReadAddress}),
                64'({vecs[i].e_req, vecs[i].e_icr, vecs[i].e_pfr, vecs[i].e_own,
                     vecs[i].e_mrg, 1'b0, vecs[i].e_addr}));
            if (vecs[i].e_icr)
                chk($sformatf("vec%0d_icdata", i), 64'({ic_blockIndex, ic_data}),
                    64'({vecs[i].mi, vecs[i].md}));
            if (vecs[i].e_pfr)
                chk($sformatf("vec%0d_pfdata", i), 64'({pf_blockIndex, pf_data}),
                    64'({vecs[i].mi, vecs[i].md}));
            step();
        end
        reset = 1'b0;

        // Demand to the prefetched block arriving at beat 2: no merge, regrant after GAP.
        ic_req = 0; pf_req = 1; pf_addr = 32'h400; drive_mem(0, 0, 0);
        step();
        drive_mem(1, 32'h60, 2'd0); step();
        drive_mem(1, 32'h61, 2'd1); step();
        drive_mem(1, 32'h62, 2'd2); ic_req = 1; ic_addr = 32'h404;
        @(negedge clk);
        chk("late_merge_b2", {61'd0, merged, ic_dataReady, pf_dataReady}, 64'd1);
        step();
        drive_mem(1, 32'h63, 2'd3);
        @(negedge clk);
        chk("late_merge_b3", {61'd0, merged, ic_dataReady, pf_dataReady}, 64'd1);
        step();
        drive_mem(0, 0, 0); pf_req = 0;
        @(negedge clk);
        chk("late_gap", 64'({owner, memReadRequest}), 64'd0);
        step();
        @(negedge clk);
        chk("late_idle", 64'({owner, memReadRequest}), 64'd0);
        step();
        @(negedge clk);
        chk("late_regrant", 64'({owner, memReadRequest, memReadAddress}),
            64'({2'b01, 1'b1, 32'h404}));
        for (int b = 0; b < 4; b++) begin
            step();
            drive_mem(1, 32'h70 + b, 2'(b));
        end
        step();
        drive_mem(0, 0, 0); ic_req = 0;
        step(); step();

        // Prefetch whose data never arrives.
        pf_req = 1; pf_addr = 32'h600;
        step();
        req_n = 0; tmo_n = 0; tmo_at = 0; rdy_n = 0; gap_owner = 2'b11;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (memReadRequest) req_n++;
            if (timeout_err) begin
                tmo_n++;
                tmo_at = req_n;
            end
            if (ic_dataReady || pf_dataReady) rdy_n++;
            if (!memReadRequest) begin
                gap_owner = owner;
                break;
            end
            step();
            if (tmo_n > 0) pf_req = 0;
        end
        chk("tmo_req_cycles", 64'(req_n), 64'd64);
        chk("tmo_pulses", 64'(tmo_n), 64'd1);
        chk("tmo_position", 64'(tmo_at), 64'd64);
        chk("tmo_no_data", 64'(rdy_n), 64'd0);
        chk("tmo_owner_clr", 64'(gap_owner), 64'd0);
        pf_req = 0;
        step();
        @(negedge clk);
        chk("tmo_idle", 64'({owner, memReadRequest, timeout_err}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
